a1335_i2c_target: RTL and testbench

A1335_I2C_TARGET -- requirements
Module: a1335_i2c_target

---
 rtl/a1335_i2c_target.sv | 246 ++++++++++++++++++++++++
 tb/tb_a1335_i2c_target.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/a1335_i2c_target.sv
// I2C target serving a 4-byte angle/status register window, with byte writes
// reported through a wr_valid/wr_addr/wr_data strobe. SCL and SDA are
// synchronized and edge-detected in the clock domain. SDA is open-drain:
// sda_oe = 1 pulls the line low.
module a1335_i2c_target #(
  parameter logic [7:0] REG_BASE = 8'h20
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [6:0]  device_id,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic [15:0] angle,
  input  logic [15:0] status,
  output logic        wr_valid,
  output logic [7:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_BYTE, S_WR_ACK, S_RD_BYTE, S_RD_ACK, S_IGNORE
  } state_t;

  // [0],[1] form the synchronizer; [2] holds the previous synchronized level
  logic [2:0]  scl_q, sda_q;
  logic        scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

  state_t      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  ptr_q, ptr_d;
  logic [31:0] shadow_q, shadow_d;
  logic        rw_q, rw_d;
  logic        first_q, first_d;
  logic        sda_oe_q, sda_oe_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        wr_valid_q, wr_valid_d;
  logic [7:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;

  // Byte served for a pointer; offsets outside the window read as zero
  function automatic logic [7:0] read_map(input logic [7:0] p, input logic [31:0] w);
    logic [7:0] off;
    off = p - REG_BASE;
    case (off)
      8'd0:    read_map = w[31:24];
      8'd1:    read_map = w[23:16];
      8'd2:    read_map = w[15:8];
      8'd3:    read_map = w[7:0];
      default: read_map = 8'h00;
    endcase
  endfunction

  assign scl_s     = scl_q[1];
  assign sda_s     = sda_q[1];
  assign scl_rise  = scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] & scl_q[2];
  assign start_det = scl_s & ~sda_q[1] & sda_q[2];
  assign stop_det  = scl_s & sda_q[1] & ~sda_q[2];

  assign sda_oe   = sda_oe_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;

  // Bring the bus pins into the clock domain; idle-high so reset makes no edge
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl_in};
      sda_q <= {sda_q[1:0], sda_in};
    end
  end

  // State and datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'h00;
      tx_q       <= 8'h00;
      ptr_q      <= 8'h00;
      shadow_q   <= 32'h0;
      rw_q       <= 1'b0;
      first_q    <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= 8'h00;
      wr_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      ptr_q      <= ptr_d;
      shadow_q   <= shadow_d;
      rw_q       <= rw_d;
      first_q    <= first_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // Next-state logic: START/STOP override everything, otherwise bit-level protocol
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    ptr_d      = ptr_q;
    shadow_d   = shadow_q;
    rw_d       = rw_q;
    first_d    = first_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    if (stop_det) begin
      state_d  = S_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      done_d   = busy_q;
    end else if (start_det) begin
      // busy survives a repeated START until the address is judged
      state_d   = S_ADDR;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
    end else begin
      case (state_q)
        S_ADDR: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              rw_d = shift_d[0];
              if (shift_d[7:1] == device_id) begin
                state_d = S_ADDR_ACK;
                busy_d  = 1'b1;
              end else begin
                state_d = S_IGNORE;
                busy_d  = 1'b0;
              end
            end
          end
        end
        S_ADDR_ACK: begin
          // first fall starts the ACK, second fall ends it
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              bit_cnt_d = 4'd0;
              if (rw_q) begin
                shadow_d = {angle, status};
                tx_d     = read_map(ptr_q, {angle, status});
                sda_oe_d = ~tx_d[7];
                state_d  = S_RD_BYTE;
              end else begin
                sda_oe_d = 1'b0;
                first_d  = 1'b1;
                state_d  = S_WR_BYTE;
              end
            end
          end
        end
        S_WR_BYTE: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              state_d   = S_WR_ACK;
              if (first_q) begin
                ptr_d   = shift_d;
                first_d = 1'b0;
              end else begin
                wr_valid_d = 1'b1;
                wr_addr_d  = ptr_q;
                wr_data_d  = shift_d;
                ptr_d      = ptr_q + 8'd1;
              end
            end
          end
        end
        S_WR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = S_WR_BYTE;
            end
          end
        end
        S_RD_BYTE: begin
          // bit_cnt counts SCL rises of the byte; the next bit goes out on the fall
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = S_RD_ACK;
            end else begin
              sda_oe_d = ~tx_q[3'd7 - bit_cnt_q[2:0]];
            end
          end
        end
        S_RD_ACK: begin
          // bit_cnt = 1 marks a received ACK awaiting the fall that starts the next byte
          if (scl_rise) begin
            ptr_d = ptr_q + 8'd1;
            if (sda_s) state_d = S_IGNORE;
            else       bit_cnt_d = 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd1) begin
            tx_d      = read_map(ptr_q, shadow_q);
            sda_oe_d  = ~tx_d[7];
            bit_cnt_d = 4'd0;
            state_d   = S_RD_BYTE;
          end
        end
        S_IGNORE: sda_oe_d = 1'b0;
        default:  ;
      endcase
    end
  end

endmodule

// File: tb/tb_a1335_i2c_target.sv
// Directed bench: an I2C master model drives SCL/SDA over an open-drain line,
// a table of pointer-write/read transactions is replayed, then hand-written
// sequences cover writes, address mismatch, shadowing and mid-read reset.
module tb_a1335_i2c_target;

  localparam int Q = 8;  // clocks per quarter SCL period

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [6:0]  device_id = 7'h0C;
  logic        m_scl = 1'b1;
  logic        m_sda = 1'b1;
  logic        sda_line;
  logic        sda_oe;
  logic [15:0] angle = 16'hA5C3;
  logic [15:0] status = 16'h0081;
  logic        wr_valid, busy, done;
  logic [7:0]  wr_addr, wr_data;

  assign sda_line = m_sda & ~sda_oe;

  a1335_i2c_target dut (
    .clock(clock), .reset_n(reset_n), .device_id(device_id),
    .scl_in(m_scl), .sda_in(sda_line), .sda_oe(sda_oe),
    .angle(angle), .status(status),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Bus monitor: cycle counts of the strobes plus a log of write strobes
  int done_cnt = 0;
  int oe_cnt = 0;
  int busy_cnt = 0;
  logic [7:0] wa_log[$];
  logic [7:0] wd_log[$];
  always @(negedge clock) begin
    if (done)   done_cnt++;
    if (sda_oe) oe_cnt++;
    if (busy)   busy_cnt++;
    if (wr_valid) begin
      wa_log.push_back(wr_addr);
      wd_log.push_back(wr_data);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wq();
    repeat (Q) @(negedge clock);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wq();
    m_scl = 1'b1; wq();
    m_sda = 1'b0; wq();
    m_scl = 1'b0; wq();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wq();
    m_scl = 1'b1; wq();
    m_sda = 1'b1; wq();
  endtask

  task automatic write_bit(input logic b);
    m_sda = b; wq();
    m_scl = 1'b1; wq(); wq();
    m_scl = 1'b0; wq();
  endtask

  task automatic read_bit(output logic b);
    m_sda = 1'b1; wq();
    m_scl = 1'b1; wq();
    b = sda_line; wq();
    m_scl = 1'b0; wq();
  endtask

  // Returns the level seen on the ninth clock (0 = ACK)
  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    logic b;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      d = {d[6:0], b};
    end
    write_bit(nack);
  endtask

  typedef struct {
    logic [7:0]  ptr;
    int          n;
    logic [31:0] exp;  // expected bytes, first byte in [31:24]
  } rd_vec_t;

  rd_vec_t vecs[6];

  initial begin
    logic       ack, b;
    logic [7:0] d;
    int         d0, oe0, b0, w0;

    vecs[0] = '{ptr: 8'h20, n: 3, exp: 32'hA5C3_0000};
    vecs[1] = '{ptr: 8'h21, n: 3, exp: 32'hC300_8100};
    vecs[2] = '{ptr: 8'h1F, n: 3, exp: 32'h00A5_C300};
    vecs[3] = '{ptr: 8'hFF, n: 2, exp: 32'h0000_0000};
    vecs[4] = '{ptr: 8'h23, n: 2, exp: 32'h8100_0000};
    vecs[5] = '{ptr: 8'h40, n: 1, exp: 32'h0000_0000};

    // Reset state
    repeat (4) @(negedge clock);
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_wr_valid", wr_valid, 1'b0);
    check("rst_wr_addr", wr_addr, 8'h00);
    check("rst_wr_data", wr_data, 8'h00);
    reset_n = 1'b1;
    repeat (10) @(negedge clock);
    check("idle_busy", busy, 1'b0);

    // Table: set pointer, repeated START, read n bytes, STOP
    for (int v = 0; v < 6; v++) begin
      d0 = done_cnt;
      i2c_start();
      write_byte(8'h18, ack); check("tbl_addr_w_ack", ack, 1'b0);
      write_byte(vecs[v].ptr, ack); check("tbl_ptr_ack", ack, 1'b0);
      i2c_start();
      write_byte(8'h19, ack); check("tbl_addr_r_ack", ack, 1'b0);
      check("tbl_busy", busy, 1'b1);
      for (int i = 0; i < vecs[v].n; i++) begin
        read_byte(d, (i == vecs[v].n - 1));
        check($sformatf("tbl%0d_byte%0d", v, i), d, vecs[v].exp[31-8*i -: 8]);
      end
      i2c_stop();
      check("tbl_done_once", done_cnt - d0, 1);
      check("tbl_busy_clr", busy, 1'b0);
      $display("txn read ptr=%h n=%0d", vecs[v].ptr, vecs[v].n);
    end

    // Write 0x22, then data 5A, 7E
    w0 = wa_log.size();
    i2c_start();
    write_byte(8'h18, ack); check("wr_addr_ack", ack, 1'b0);
    write_byte(8'h22, ack); check("wr_ptr_ack", ack, 1'b0);
    write_byte(8'h5A, ack); check("wr_d0_ack", ack, 1'b0);
    write_byte(8'h7E, ack); check("wr_d1_ack", ack, 1'b0);
    i2c_stop();
    check("wr_count", wa_log.size() - w0, 2);
    if (wa_log.size() >= w0 + 2) begin
      check("wr0_addr", wa_log[w0], 8'h22);
      check("wr0_data", wd_log[w0], 8'h5A);
      check("wr1_addr", wa_log[w0+1], 8'h23);
      check("wr1_data", wd_log[w0+1], 8'h7E);
    end
    $display("txn write ptr=22 data=5A,7E");

    // Pointer persists: write from 1E leaves ptr at 20, plain read starts there
    w0 = wa_log.size();
    i2c_start();
    write_byte(8'h18, ack);
    write_byte(8'h1E, ack);
    write_byte(8'hAA, ack);
    write_byte(8'hBB, ack);
    i2c_stop();
    check("wr2_count", wa_log.size() - w0, 2);
    if (wa_log.size() >= w0 + 2) begin
      check("wr2_addr1", wa_log[w0+1], 8'h1F);
      check("wr2_data1", wd_log[w0+1], 8'hBB);
    end
    i2c_start();
    write_byte(8'h19, ack); check("persist_ack", ack, 1'b0);
    read_byte(d, 1'b0); check("persist_b0", d, 8'hA5);
    read_byte(d, 1'b1); check("persist_b1", d, 8'hC3);
    i2c_stop();
    $display("txn write ptr=1E data=AA,BB then read");

    // Write pointer wrap FF -> 00
    w0 = wa_log.size();
    i2c_start();
    write_byte(8'h18, ack);
    write_byte(8'hFF, ack);
    write_byte(8'h11, ack);
    write_byte(8'h22, ack);
    i2c_stop();
    check("wrap_count", wa_log.size() - w0, 2);
    if (wa_log.size() >= w0 + 2) begin
      check("wrap_addr0", wa_log[w0], 8'hFF);
      check("wrap_addr1", wa_log[w0+1], 8'h00);
    end
    $display("txn write ptr=FF data=11,22");

    // Address mismatch: no ACK, never busy, no done
    d0 = done_cnt; oe0 = oe_cnt; b0 = busy_cnt;
    i2c_start();
    write_byte(8'h1A, ack); check("mis_nack", ack, 1'b1);
    i2c_stop();
    check("mis_oe_cycles", oe_cnt - oe0, 0);
    check("mis_busy_cycles", busy_cnt - b0, 0);
    check("mis_done", done_cnt - d0, 0);
    $display("txn mismatch addr=1A");

    // Shadow: angle changes between byte 1 and byte 2
    i2c_start();
    write_byte(8'h18, ack);
    write_byte(8'h20, ack);
    i2c_start();
    write_byte(8'h19, ack);
    read_byte(d, 1'b0); check("shadow_b0", d, 8'hA5);
    angle = 16'h1234;
    read_byte(d, 1'b1); check("shadow_b1", d, 8'hC3);
    i2c_stop();
    i2c_start();
    write_byte(8'h18, ack);
    write_byte(8'h20, ack);
    i2c_start();
    write_byte(8'h19, ack);
    read_byte(d, 1'b1); check("resnap_b0", d, 8'h12);
    i2c_stop();
    angle = 16'hA5C3;
    $display("txn shadow read");

    // Reset while the target drives read bit 3 (A5 bit 3 is 0, so SDA is low)
    i2c_start();
    write_byte(8'h18, ack);
    write_byte(8'h20, ack);
    i2c_start();
    write_byte(8'h19, ack);
    read_bit(b); check("rst_rd_bit0", b, 1'b1);
    read_bit(b); check("rst_rd_bit1", b, 1'b0);
    read_bit(b); check("rst_rd_bit2", b, 1'b1);
    m_sda = 1'b1; wq();
    m_scl = 1'b1; wq();
    check("rst_pre_oe", sda_oe, 1'b1);
    #2 reset_n = 1'b0;
    #1 check("rst_async_oe", sda_oe, 1'b0);
    check("rst_async_busy", busy, 1'b0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    wq();
    m_scl = 1'b0; wq();
    d0 = done_cnt;
    i2c_stop();
    check("rst_no_done", done_cnt - d0, 0);
    d0 = done_cnt;
    i2c_start();
    write_byte(8'h18, ack); check("post_rst_ack", ack, 1'b0);
    write_byte(8'h20, ack);
    i2c_start();
    write_byte(8'h19, ack);
    read_byte(d, 1'b0); check("post_rst_b0", d, 8'hA5);
    read_byte(d, 1'b1); check("post_rst_b1", d, 8'hC3);
    i2c_stop();
    check("post_rst_done", done_cnt - d0, 1);
    $display("txn reset mid-read then read");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
